// File: rtl/ser_tx_pkg.sv
// Definitions shared by the serial transmitter and receiver: clock defaults,
// bit-period derivation and the line FSM state encoding.
package ser_tx_pkg;

   localparam int unsigned IN_CLK_DEF  = 25_000_000;
   localparam int unsigned OUT_CLK_DEF = 57_600;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_DATA  = 2'd2;
   localparam state_t ST_STOP  = 2'd3;

   // Truncating division: the bit period is always a whole number of clocks.
   function automatic int unsigned clk_div(input int unsigned in_clk,
                                           input int unsigned out_clk);
      return in_clk / out_clk;
   endfunction

endpackage

// File: rtl/ser_tx_fifo.sv
// Single-clock synchronous byte FIFO with registered occupancy and a
// registered not-full flag, so the accept signal never depends on this cycle's pop.
module ser_tx_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [DATA_W-1:0]         wdata_i,
   output logic [DATA_W-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic                      ready_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [AW:0] FULL = LW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q;
   logic [AW-1:0]     rd_q;
   logic [AW:0]       level_q;
   logic [AW:0]       level_d;
   logic              ready_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push_i && ready_q;
   assign do_pop  = pop_i && (level_q != '0);

   always_comb begin
      level_d = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + LW'(1);
      end else if (!do_push && do_pop) begin
         level_d = level_q - LW'(1);
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         ready_q <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         level_q <= level_d;
         ready_q <= (level_d != FULL);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign level_o = level_q;
   assign ready_o = ready_q;

endmodule

// File: rtl/ser_tx.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop line FSM
// with a per-bit baud counter and a registered line output.
module ser_tx
   import ser_tx_pkg::*;
#(
   parameter int unsigned IN_CLK  = IN_CLK_DEF,
   parameter int unsigned OUT_CLK = OUT_CLK_DEF,
   parameter int unsigned DEPTH   = 16
) (
   input  logic                    pixclk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_data,
   output logic                    serialtx,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned CLK_DIV = clk_div(IN_CLK, OUT_CLK);
   localparam int unsigned CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          pop;
   logic          bit_end;
   logic          fifo_empty;
   logic [7:0]    head;

   ser_tx_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk_i   (pixclk),
      .rst_ni  (rst_n),
      .push_i  (in_valid),
      .pop_i   (pop),
      .wdata_i (in_data),
      .rdata_o (head),
      .level_o (level),
      .ready_o (in_ready)
   );

   assign fifo_empty = (level == '0);
   assign bit_end    = (cnt_q == CNT_LAST);

   // tx_d is the level for the cycle after this edge, so every transition
   // loads the first level of the next bit alongside the state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               cnt_d   = '0;
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pixclk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   always_ff @(posedge pixclk) begin
      shift_q <= shift_d;
   end

   assign serialtx = tx_q;
   assign busy     = (state_q != ST_IDLE) || (level != '0);

endmodule
